// File: rtl/decode_stage.sv
// RV32I decode stage: decodes one instruction per cycle into a registered bundle
// with writeback bypass and a valid/ready handshake on both sides.
module decode_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic            flush,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  input  logic [XLEN-1:0] rdata1,
  input  logic [XLEN-1:0] rdata2,
  input  logic            wb_wen,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_op1,
  output logic [XLEN-1:0] out_op2,
  output logic [XLEN-1:0] out_imm,
  output logic [4:0]      out_rd,
  output logic            out_wen,
  output logic [6:0]      out_opcode,
  output logic [2:0]      out_funct3,
  output logic [3:0]      out_alu_op,
  output logic            out_illegal
);

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_SLL   = 4'd2,
    ALU_SLT   = 4'd3,
    ALU_SLTU  = 4'd4,
    ALU_XOR   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_OR    = 4'd8,
    ALU_AND   = 4'd9,
    ALU_PASSB = 4'd10
  } aluOp_t;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  logic [6:0]      w_opcode;
  logic [2:0]      w_funct3;
  logic [4:0]      w_rd;
  logic            w_alt;
  logic [XLEN-1:0] w_imm;
  aluOp_t          w_aluOp;
  aluOp_t          w_funcOp;
  logic            w_writes;
  logic            w_illegal;
  logic            w_wen;
  logic [XLEN-1:0] w_op1;
  logic [XLEN-1:0] w_op2;
  logic            w_capture;

  logic            r_valid;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_op1;
  logic [XLEN-1:0] r_op2;
  logic [XLEN-1:0] r_imm;
  logic [4:0]      r_rd;
  logic            r_wen;
  logic [6:0]      r_opcode;
  logic [2:0]      r_funct3;
  aluOp_t          r_aluOp;
  logic            r_illegal;

  assign w_opcode = in_instr[6:0];
  assign w_funct3 = in_instr[14:12];
  assign w_rd     = in_instr[11:7];
  assign w_alt    = in_instr[30];
  assign rs1      = in_instr[19:15];
  assign rs2      = in_instr[24:20];

  assign in_ready  = !r_valid || out_ready;
  assign w_capture = in_valid && in_ready && !flush;

  // Register x0 always reads zero; otherwise a same-cycle writeback wins over the file.
  assign w_op1 = (rs1 == 5'd0) ? '0 : ((wb_wen && wb_rd == rs1) ? wb_data : rdata1);
  assign w_op2 = (rs2 == 5'd0) ? '0 : ((wb_wen && wb_rd == rs2) ? wb_data : rdata2);

  always_comb begin
    w_funcOp = ALU_ADD;
    unique case (w_funct3)
      3'b000: w_funcOp = ALU_ADD;
      3'b001: w_funcOp = ALU_SLL;
      3'b010: w_funcOp = ALU_SLT;
      3'b011: w_funcOp = ALU_SLTU;
      3'b100: w_funcOp = ALU_XOR;
      3'b101: w_funcOp = w_alt ? ALU_SRA : ALU_SRL;
      3'b110: w_funcOp = ALU_OR;
      3'b111: w_funcOp = ALU_AND;
    endcase
  end

  always_comb begin
    w_imm     = '0;
    w_aluOp   = ALU_ADD;
    w_writes  = 1'b0;
    w_illegal = 1'b0;
    case (w_opcode)
      OPC_LUI: begin
        w_imm    = {in_instr[31:12], 12'b0};
        w_aluOp  = ALU_PASSB;
        w_writes = 1'b1;
      end
      OPC_AUIPC: begin
        w_imm    = {in_instr[31:12], 12'b0};
        w_writes = 1'b1;
      end
      OPC_JAL: begin
        w_imm    = {{(XLEN-20){in_instr[31]}}, in_instr[19:12], in_instr[20],
                    in_instr[30:21], 1'b0};
        w_writes = 1'b1;
      end
      OPC_JALR, OPC_LOAD: begin
        w_imm    = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
        w_writes = 1'b1;
      end
      OPC_STORE: begin
        w_imm = {{(XLEN-12){in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      end
      OPC_BRANCH: begin
        w_imm = {{(XLEN-12){in_instr[31]}}, in_instr[7], in_instr[30:25],
                 in_instr[11:8], 1'b0};
      end
      OPC_OPIMM: begin
        w_imm    = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
        // Immediate forms have no subtract; bit 30 is part of the immediate for ADDI.
        w_aluOp  = (w_funct3 == 3'b000) ? ALU_ADD : w_funcOp;
        w_writes = 1'b1;
      end
      OPC_OP: begin
        w_aluOp  = (w_funct3 == 3'b000 && w_alt) ? ALU_SUB : w_funcOp;
        w_writes = 1'b1;
      end
      default: w_illegal = 1'b1;
    endcase
  end

  assign w_wen = w_writes && (w_rd != 5'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid   <= 1'b0;
      r_pc      <= '0;
      r_op1     <= '0;
      r_op2     <= '0;
      r_imm     <= '0;
      r_rd      <= '0;
      r_wen     <= 1'b0;
      r_opcode  <= '0;
      r_funct3  <= '0;
      r_aluOp   <= ALU_ADD;
      r_illegal <= 1'b0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (w_capture) begin
      r_valid   <= 1'b1;
      r_pc      <= in_pc;
      r_op1     <= w_op1;
      r_op2     <= w_op2;
      r_imm     <= w_imm;
      r_rd      <= w_rd;
      r_wen     <= w_wen;
      r_opcode  <= w_opcode;
      r_funct3  <= w_funct3;
      r_aluOp   <= w_aluOp;
      r_illegal <= w_illegal;
    end else if (r_valid && out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign out_valid   = r_valid;
  assign out_pc      = r_pc;
  assign out_op1     = r_op1;
  assign out_op2     = r_op2;
  assign out_imm     = r_imm;
  assign out_rd      = r_rd;
  assign out_wen     = r_wen;
  assign out_opcode  = r_opcode;
  assign out_funct3  = r_funct3;
  assign out_alu_op  = r_aluOp;
  assign out_illegal = r_illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed cases followed by randomized
// traffic compared against a transaction-level reference model.
module tb_decode_stage;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        flush;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [31:0] rdata1;
  logic [31:0] rdata2;
  logic        wb_wen;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_op1;
  logic [31:0] out_op2;
  logic [31:0] out_imm;
  logic [4:0]  out_rd;
  logic        out_wen;
  logic [6:0]  out_opcode;
  logic [2:0]  out_funct3;
  logic [3:0]  out_alu_op;
  logic        out_illegal;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic        wen;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [3:0]  aluOp;
    logic        illegal;
  } bundle_t;

  int      compareCount = 0;
  int      failCount = 0;
  logic    expValid;
  bundle_t expBundle;

  decode_stage #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .flush(flush), .rs1(rs1), .rs2(rs2), .rdata1(rdata1), .rdata2(rdata2),
    .wb_wen(wb_wen), .wb_rd(wb_rd), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_op1(out_op1), .out_op2(out_op2), .out_imm(out_imm), .out_rd(out_rd),
    .out_wen(out_wen), .out_opcode(out_opcode), .out_funct3(out_funct3),
    .out_alu_op(out_alu_op), .out_illegal(out_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h at %0t", tag, observed,
               expected, $time);
    end
  endtask

  // Expected decode derived from the instruction-set rules with plain arithmetic.
  function automatic bundle_t refDecode(input logic [31:0] instr, input logic [31:0] pc,
                                        input logic [31:0] rd1, input logic [31:0] rd2,
                                        input logic wwen, input logic [4:0] wrd,
                                        input logic [31:0] wdata);
    bundle_t b;
    int s;
    logic [31:0] sx;
    logic [4:0] r1;
    logic [4:0] r2;
    logic [2:0] f3;
    logic [3:0] aluTbl [8] = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};
    b = '0;
    s = int'($signed(instr));
    sx = 32'(s >>> 31);
    r1 = instr[19:15];
    r2 = instr[24:20];
    f3 = instr[14:12];
    b.pc = pc;
    b.opcode = instr[6:0];
    b.funct3 = f3;
    b.rd = instr[11:7];
    b.op1 = (r1 == 0) ? 32'd0 : ((wwen && wrd == r1) ? wdata : rd1);
    b.op2 = (r2 == 0) ? 32'd0 : ((wwen && wrd == r2) ? wdata : rd2);
    case (instr[6:0])
      7'h37: begin b.imm = instr & 32'hFFFFF000; b.aluOp = 4'd10; b.wen = 1'b1; end
      7'h17: begin b.imm = instr & 32'hFFFFF000; b.wen = 1'b1; end
      7'h6F: begin
        b.imm = (sx << 20) | (32'(instr[19:12]) << 12) | (32'(instr[20]) << 11)
              | (32'(instr[30:21]) << 1);
        b.wen = 1'b1;
      end
      7'h67, 7'h03: begin b.imm = 32'(s >>> 20); b.wen = 1'b1; end
      7'h23: b.imm = 32'((s >>> 25) << 5) | 32'(instr[11:7]);
      7'h63: b.imm = (sx << 12) | (32'(instr[7]) << 11) | (32'(instr[30:25]) << 5)
                   | (32'(instr[11:8]) << 1);
      7'h13: begin
        b.imm = 32'(s >>> 20);
        b.aluOp = aluTbl[f3] + ((f3 == 3'd5 && instr[30]) ? 4'd1 : 4'd0);
        b.wen = 1'b1;
      end
      7'h33: begin
        b.aluOp = aluTbl[f3] + (((f3 == 3'd0 || f3 == 3'd5) && instr[30]) ? 4'd1 : 4'd0);
        b.wen = 1'b1;
      end
      default: b.illegal = 1'b1;
    endcase
    b.wen = b.wen && (b.rd != 5'd0);
    return b;
  endfunction

  task automatic compareBundle(input string tag);
    checkOutput({tag, "_valid"}, 32'(out_valid), 32'(expValid));
    if (expValid) begin
      checkOutput({tag, "_pc"}, out_pc, expBundle.pc);
      checkOutput({tag, "_op1"}, out_op1, expBundle.op1);
      checkOutput({tag, "_op2"}, out_op2, expBundle.op2);
      checkOutput({tag, "_imm"}, out_imm, expBundle.imm);
      checkOutput({tag, "_wen"}, 32'(out_wen), 32'(expBundle.wen));
      if (expBundle.wen) checkOutput({tag, "_rd"}, 32'(out_rd), 32'(expBundle.rd));
      checkOutput({tag, "_opcode"}, 32'(out_opcode), 32'(expBundle.opcode));
      checkOutput({tag, "_funct3"}, 32'(out_funct3), 32'(expBundle.funct3));
      checkOutput({tag, "_aluop"}, 32'(out_alu_op), 32'(expBundle.aluOp));
      checkOutput({tag, "_illegal"}, 32'(out_illegal), 32'(expBundle.illegal));
    end
  endtask

  // One clock of stimulus: drive on the falling edge, check combinational outputs,
  // advance the model, then check the registered bundle just after the rising edge.
  task automatic applyStimulus(input string tag, input logic [31:0] instr,
                               input logic [31:0] pc, input logic valid,
                               input logic fl, input logic oready,
                               input logic [31:0] rd1, input logic [31:0] rd2,
                               input logic wwen, input logic [4:0] wrd,
                               input logic [31:0] wdata);
    logic expReady;
    logic capture;
    @(negedge clk);
    in_instr = instr; in_pc = pc; in_valid = valid; flush = fl; out_ready = oready;
    rdata1 = rd1; rdata2 = rd2; wb_wen = wwen; wb_rd = wrd; wb_data = wdata;
    #1;
    expReady = !expValid || oready;
    checkOutput({tag, "_inready"}, 32'(in_ready), 32'(expReady));
    checkOutput({tag, "_rs1"}, 32'(rs1), 32'(instr[19:15]));
    checkOutput({tag, "_rs2"}, 32'(rs2), 32'(instr[24:20]));
    capture = valid && expReady && !fl;
    if (fl) expValid = 1'b0;
    else if (capture) begin
      expValid = 1'b1;
      expBundle = refDecode(instr, pc, rd1, rd2, wwen, wrd, wdata);
    end else if (expValid && oready) expValid = 1'b0;
    @(posedge clk);
    #1;
    compareBundle(tag);
  endtask

  logic [6:0] opTbl [9] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};

  initial begin
    logic [31:0] rInstr;
    rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; flush = 1'b0;
    rdata1 = '0; rdata2 = '0; wb_wen = 1'b0; wb_rd = '0; wb_data = '0; out_ready = 1'b0;
    expValid = 1'b0;
    expBundle = '0;
    $display("[TB] starting decode_stage bench");
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_pc", out_pc, 32'd0);
    checkOutput("reset_imm", out_imm, 32'd0);
    checkOutput("reset_op1", out_op1, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // ADDI x5,x1,3 on the first edge after reset release
    applyStimulus("addi", 32'h00308293, 32'h100, 1, 0, 1, 32'd7, 32'd0, 0, 5'd0, 32'd0);
    checkOutput("addi_lit_rd", 32'(out_rd), 32'd5);
    checkOutput("addi_lit_imm", out_imm, 32'd3);
    checkOutput("addi_lit_op1", out_op1, 32'd7);

    applyStimulus("sw", 32'hFE20AE23, 32'h104, 1, 0, 1, 32'd1, 32'd2, 0, 5'd0, 32'd0);
    checkOutput("sw_lit_imm", out_imm, 32'hFFFFFFFC);
    checkOutput("sw_lit_wen", 32'(out_wen), 32'd0);

    // Bypass from writeback on rs1, then x0 is immune to bypass
    applyStimulus("byp1", 32'h00308293, 32'h108, 1, 0, 1, 32'd3, 32'd0, 1, 5'd1, 32'h11);
    checkOutput("byp1_lit_op1", out_op1, 32'h11);
    applyStimulus("byp0", 32'h00300293, 32'h10C, 1, 0, 1, 32'd3, 32'd0, 1, 5'd0, 32'h11);
    checkOutput("byp0_lit_op1", out_op1, 32'd0);

    // Stall three cycles, then the waiting instruction is taken on the release edge
    applyStimulus("stall_cap", 32'h40208133, 32'h200, 1, 0, 0, 32'd9, 32'd4, 0, 5'd0, 32'd0);
    for (int i = 0; i < 3; i++)
      applyStimulus("stall_hold", 32'h0000A183, 32'h204, 1, 0, 0, 32'd5, 32'd6, 0, 5'd0, 32'd0);
    applyStimulus("stall_rel", 32'h0000A183, 32'h204, 1, 0, 1, 32'd5, 32'd6, 0, 5'd0, 32'd0);

    // Flush while a bundle is held and another is offered
    applyStimulus("fl_cap", 32'h12345037, 32'h300, 1, 0, 0, 32'd0, 32'd0, 0, 5'd0, 32'd0);
    applyStimulus("flush", 32'h00500113, 32'h304, 1, 1, 0, 32'd0, 32'd0, 0, 5'd0, 32'd0);
    applyStimulus("fl_after", 32'h00500113, 32'h308, 0, 0, 1, 32'd0, 32'd0, 0, 5'd0, 32'd0);

    applyStimulus("illegal", 32'h00000000, 32'h400, 1, 0, 0, 32'd0, 32'd0, 0, 5'd0, 32'd0);
    checkOutput("illegal_lit", 32'(out_illegal), 32'd1);

    // Asynchronous reset while the illegal bundle is stalled
    #2;
    rst_n = 1'b0;
    #1;
    expValid = 1'b0;
    checkOutput("async_rst_valid", 32'(out_valid), 32'd0);
    checkOutput("async_rst_illegal", 32'(out_illegal), 32'd0);
    checkOutput("async_rst_pc", out_pc, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus("post_rst", 32'h800000EF, 32'h500, 1, 0, 1, 32'd0, 32'd0, 0, 5'd0, 32'd0);

    for (int n = 0; n < 400; n++) begin
      rInstr = $urandom;
      if ($urandom_range(0, 9) != 0) rInstr[6:0] = opTbl[$urandom_range(0, 8)];
      if ($urandom_range(0, 1) == 1) rInstr[19:15] = 5'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) rInstr[24:20] = 5'($urandom_range(0, 3));
      applyStimulus("rand", rInstr, $urandom, ($urandom_range(0, 4) != 0),
                    ($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0),
                    $urandom, $urandom, 1'($urandom_range(0, 1)),
                    5'($urandom_range(0, 3)), $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule
